// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller states and
// a helper that sizes the bit counter from the operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1; never less than one.
  function automatic int cnt_width(input int w);
    if (w <= 2) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the serial adder's arithmetic slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// one operand bit per clock, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for Start; Sum/Cout hold the last result
// RUN   | shifting one bit pair per clock through the adder cell
// DONE  | one-cycle result-valid pulse; Start here reloads immediately
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             accept;
  logic             finish;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (bit_sum),
    .Cout (bit_carry)
  );

  // Next-state decode; accept/finish mark the load and completion edges.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand shifters, carry flop, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      s_sh  <= {bit_sum, s_sh[WIDTH-1:1]};
      carry <= bit_carry;
      if (finish) begin
        // Result becomes visible only here; partial sums stay internal.
        cnt  <= '0;
        Sum  <= {bit_sum, s_sh[WIDTH-1:1]};
        Cout <= bit_carry;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): handshake timing, carries,
// Start ignored in RUN, back-to-back operation, reset abort, random pairs.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;

  int total = 0;
  int bad = 0;

  int           cyc;
  bit           busy_ok;
  bit           sum_stable;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;
  logic [W:0]   ref_full;
  int           extra_done;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count cycles until Done (bounded); Busy must be high and Sum frozen meanwhile.
  task automatic wait_done();
    logic [W-1:0] held;
    held       = Sum;
    cyc        = 0;
    busy_ok    = 1'b1;
    sum_stable = 1'b1;
    while (!Done && cyc < 20) begin
      if (!Busy) busy_ok = 1'b0;
      if (Sum !== held) sum_stable = 1'b0;
      tick();
      cyc++;
    end
  endtask

  // Present operands with Start for one accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    Start = 1'b1;
    A = a;
    B = b;
    Cin = c;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", Busy, 0);

    // 1: 0x5A + 0x3C
    launch(8'h5A, 8'h3C, 1'b0);
    check("t1_busy_after_accept", Busy, 1);
    wait_done();
    check("t1_latency", cyc, 8);
    check("t1_busy_during_run", busy_ok, 1);
    check("t1_busy_in_done", Busy, 0);
    check("t1_sum", Sum, 8'h96);
    check("t1_cout", Cout, 0);
    tick();
    check("t1_done_pulse_width", Done, 0);
    check("t1_sum_held_idle", Sum, 8'h96);

    // 2: carry-out cases
    launch(8'hFF, 8'h01, 1'b0);
    wait_done();
    check("t2a_latency", cyc, 8);
    check("t2a_sum", Sum, 8'h00);
    check("t2a_cout", Cout, 1);
    tick();
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done();
    check("t2b_sum_stable", sum_stable, 1);
    check("t2b_sum", Sum, 8'hFF);
    check("t2b_cout", Cout, 1);
    tick();

    // 3: Start with new operands during RUN is ignored
    launch(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    Start = 1'b1;
    A = 8'hAA;
    B = 8'h55;
    Cin = 1'b1;
    tick();
    A = 8'h33;
    B = 8'hCC;
    tick();
    Start = 1'b0;
    wait_done();
    check("t3_latency", cyc + 4, 8);
    check("t3_sum", Sum, 8'h30);
    check("t3_cout", Cout, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done) extra_done++;
    end
    check("t3_single_done", extra_done, 0);

    // 4: Start held high, back-to-back operations
    Start = 1'b1;
    A = 8'h01;
    B = 8'h01;
    Cin = 1'b0;
    tick();
    wait_done();
    check("t4a_latency", cyc, 8);
    check("t4a_sum", Sum, 8'h02);
    check("t4a_cout", Cout, 0);
    check("t4a_busy_low_done", Busy, 0);
    A = 8'h80;
    B = 8'h80;
    tick();
    check("t4_reaccept_busy", Busy, 1);
    check("t4_done_dropped", Done, 0);
    wait_done();
    check("t4b_spacing", cyc + 1, 9);
    check("t4b_busy_during_run", busy_ok, 1);
    check("t4b_sum", Sum, 8'h00);
    check("t4b_cout", Cout, 1);
    Start = 1'b0;
    tick();
    check("t4_to_idle", Busy, 0);

    // 5: reset aborts a running operation
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done();
    check("t5_pre_sum", Sum, 8'h96);
    tick();
    launch(8'h01, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_abort_busy", Busy, 0);
    check("t5_abort_done", Done, 0);
    check("t5_abort_sum", Sum, 0);
    check("t5_abort_cout", Cout, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done || Busy) extra_done++;
    end
    check("t5_no_done_after_abort", extra_done, 0);
    launch(8'h0F, 8'h01, 1'b0);
    wait_done();
    check("t5_restart_latency", cyc, 8);
    check("t5_restart_sum", Sum, 8'h10);
    check("t5_restart_cout", Cout, 0);
    tick();

    // 6: random operand pairs against A+B+Cin
    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      launch(ra, rb, rc);
      A = W'($urandom);
      B = W'($urandom);
      wait_done();
      check("t6_latency", cyc, 8);
      check("t6_sum_stable", sum_stable, 1);
      check("t6_sum", Sum, ref_full[W-1:0]);
      check("t6_cout", Cout, ref_full[W]);
      if (n % 3 == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
